// File: rtl/int_ctrl.sv
// Interrupt sequencer: arbitrates reset > NMI > NUM_IRQ maskable IRQs at each sync edge.
// Define INT_CTRL_RR_EN for round-robin IRQ arbitration; otherwise the lowest eligible index wins.
module int_ctrl #(
    parameter int              NUM_IRQ      = 4,
    parameter int              ID_W         = 2,
    parameter logic [7:0]      IRQ_VEC_BASE = 8'hE0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sync,
    input  logic               i_flag,
    input  logic               nmi_n,
    input  logic [NUM_IRQ-1:0] irq_n,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_din,
    output logic               take_rst,
    output logic               take_nmi,
    output logic               take_irq,
    output logic [ID_W-1:0]    irq_id,
    output logic [7:0]         vec_lo,
    output logic [NUM_IRQ-1:0] mask
);

    logic               nmi_q;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] elig;
    logic               nmi_pend;
    logic               rst_pend;
    logic               nmi_fall;
    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic [7:0]         win_vec;

`ifdef INT_CTRL_RR_EN
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    ptr_next;
    int                 off;
    int                 best;
`endif

    assign elig     = irq_q & mask & {NUM_IRQ{~i_flag}};
    assign nmi_fall = nmi_q & ~nmi_n;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef INT_CTRL_RR_EN
        // Smallest circular distance from the pointer wins.
        off  = 0;
        best = NUM_IRQ;
        for (int k = 0; k < NUM_IRQ; k++) begin
            off = (k - int'(ptr) + NUM_IRQ) % NUM_IRQ;
            if (elig[k] && (off < best)) begin
                best      = off;
                win_found = 1'b1;
                win_idx   = ID_W'(k);
            end
        end
        ptr_next = (win_idx == ID_W'(NUM_IRQ - 1)) ? '0 : win_idx + 1'b1;
`else
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (elig[k]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(k);
            end
        end
`endif
        win_vec = (win_idx == '0) ? 8'hFE : IRQ_VEC_BASE + 8'(2 * (int'(win_idx) - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_q    <= 1'b1;
            irq_q    <= '0;
            nmi_pend <= 1'b0;
            rst_pend <= 1'b1;
            mask     <= '1;
            take_rst <= 1'b1;
            take_nmi <= 1'b0;
            take_irq <= 1'b0;
            irq_id   <= '0;
            vec_lo   <= 8'hFC;
`ifdef INT_CTRL_RR_EN
            ptr      <= '0;
`endif
        end else begin
            nmi_q <= nmi_n;
            irq_q <= ~irq_n;
            if (mask_wr)
                mask <= mask_din;
            if (nmi_fall)
                nmi_pend <= 1'b1;

            if (sync) begin
                take_rst <= 1'b0;
                take_nmi <= 1'b0;
                take_irq <= 1'b0;
                irq_id   <= '0;
                vec_lo   <= 8'hFE;
                if (rst_pend) begin
                    take_rst <= 1'b1;
                    vec_lo   <= 8'hFC;
                    rst_pend <= 1'b0;
                end else if (nmi_pend) begin
                    take_nmi <= 1'b1;
                    vec_lo   <= 8'hFA;
                    // A fresh falling edge on this same edge keeps it pending.
                    nmi_pend <= nmi_fall;
                end else if (win_found) begin
                    take_irq <= 1'b1;
                    irq_id   <= win_idx;
                    vec_lo   <= win_vec;
`ifdef INT_CTRL_RR_EN
                    ptr      <= ptr_next;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: behavioural model compared every cycle plus literal checkpoints.
module tb_int_ctrl;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         sync;
    logic         i_flag;
    logic         nmi_n;
    logic [N-1:0] irq_n;
    logic         mask_wr;
    logic [N-1:0] mask_din;
    logic         take_rst, take_nmi, take_irq;
    logic [1:0]   irq_id;
    logic [7:0]   vec_lo;
    logic [N-1:0] mask;

    int checks   = 0;
    int failures = 0;

    int_ctrl #(.NUM_IRQ(N), .ID_W(2), .IRQ_VEC_BASE(8'hE0)) dut (
        .clk(clk), .rst(rst), .sync(sync), .i_flag(i_flag), .nmi_n(nmi_n),
        .irq_n(irq_n), .mask_wr(mask_wr), .mask_din(mask_din),
        .take_rst(take_rst), .take_nmi(take_nmi), .take_irq(take_irq),
        .irq_id(irq_id), .vec_lo(vec_lo), .mask(mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int vec_of(input int k);
        return (k == 0) ? 'hFE : 'hE0 + 2 * (k - 1);
    endfunction

    // Circular search from start; -1 when nothing is eligible.
    function automatic int pick(input bit [N-1:0] req, input bit [N-1:0] msk,
                                input bit blk, input int start);
        for (int o = 0; o < N; o++) begin
            int k;
            k = (start + o) % N;
            if (req[k] && msk[k] && !blk) return k;
        end
        return -1;
    endfunction

    // Model state
    bit         started = 0;
    bit         m_prev, m_nmi_pend, m_rst_pend;
    bit [N-1:0] m_req, m_mask;
    int         m_ptr, w;
    bit         fall;
    bit         e_rst, e_nmi, e_irq;
    int         e_id, e_vec;

    always @(posedge clk) begin
        if (rst) begin
            started    = 1;
            m_prev     = 1; m_req = '0; m_nmi_pend = 0; m_rst_pend = 1;
            m_mask     = '1; m_ptr = 0;
            e_rst = 1; e_nmi = 0; e_irq = 0; e_id = 0; e_vec = 'hFC;
        end else if (started) begin
            fall = m_prev && !nmi_n;
            if (sync) begin
                e_rst = 0; e_nmi = 0; e_irq = 0; e_id = 0; e_vec = 'hFE;
                if (m_rst_pend) begin
                    e_rst = 1; e_vec = 'hFC; m_rst_pend = 0;
                end else if (m_nmi_pend) begin
                    e_nmi = 1; e_vec = 'hFA; m_nmi_pend = 0;
                end else begin
`ifdef INT_CTRL_RR_EN
                    w = pick(m_req, m_mask, i_flag, m_ptr);
`else
                    w = pick(m_req, m_mask, i_flag, 0);
`endif
                    if (w >= 0) begin
                        e_irq = 1; e_id = w; e_vec = vec_of(w);
                        m_ptr = (w + 1) % N;
                    end
                end
            end
            if (fall) m_nmi_pend = 1;
            if (mask_wr) m_mask = mask_din;
            m_prev = nmi_n;
            m_req  = ~irq_n;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cyc_take_rst", int'(take_rst), int'(e_rst));
            chk("cyc_take_nmi", int'(take_nmi), int'(e_nmi));
            chk("cyc_take_irq", int'(take_irq), int'(e_irq));
            chk("cyc_irq_id",   int'(irq_id),   e_id);
            chk("cyc_vec_lo",   int'(vec_lo),   e_vec);
            chk("cyc_mask",     int'(mask),     int'(m_mask));
        end
    end

    task automatic edge_(input logic s);
        sync = s;
        @(posedge clk);
        #1;
    endtask

    int exp_ids [4];

    initial begin
`ifdef INT_CTRL_RR_EN
        exp_ids = '{0, 1, 2, 3};
`else
        exp_ids = '{0, 0, 0, 0};
`endif
        rst = 1; sync = 0; i_flag = 0; nmi_n = 1; irq_n = 4'hF;
        mask_wr = 0; mask_din = '0;
        repeat (3) edge_(0);
        chk("rst_take_rst", int'(take_rst), 1);
        chk("rst_vec", int'(vec_lo), 'hFC);
        chk("rst_mask", int'(mask), 'hF);

        // Reset release
        rst = 0;
        edge_(0);
        edge_(1);
        chk("rel_take_rst", int'(take_rst), 1);
        chk("rel_vec", int'(vec_lo), 'hFC);
        edge_(1);
        chk("idle_take_rst", int'(take_rst), 0);
        chk("idle_vec", int'(vec_lo), 'hFE);

        // NMI beats IRQ, then IRQ channel 0
        irq_n = 4'b1110; nmi_n = 0;
        edge_(0);
        nmi_n = 1;
        edge_(1);
        chk("nmi_take", int'(take_nmi), 1);
        chk("nmi_vec", int'(vec_lo), 'hFA);
        edge_(1);
        chk("irq0_take", int'(take_irq), 1);
        chk("irq0_id", int'(irq_id), 0);
        chk("irq0_vec", int'(vec_lo), 'hFE);

        // Masking
        mask_wr = 1; mask_din = 4'b1101; irq_n = 4'b1001;
        edge_(0);
        mask_wr = 0;
        edge_(1);
        chk("mask_take", int'(take_irq), 1);
        chk("mask_id", int'(irq_id), 2);
        chk("mask_vec", int'(vec_lo), 'hE2);
        i_flag = 1;
        edge_(1);
        chk("iflag_take", int'(take_irq), 0);
        chk("iflag_vec", int'(vec_lo), 'hFE);
        i_flag = 0;

        // Arbitration from a fresh reset with all requests held
        irq_n = 4'b0000; rst = 1;
        edge_(0);
        rst = 0;
        edge_(1);
        chk("arb_rst", int'(take_rst), 1);
        for (int i = 0; i < 4; i++) begin
            edge_(1);
            chk("arb_take", int'(take_irq), 1);
            chk("arb_id", int'(irq_id), exp_ids[i]);
        end

        // NMI falling edge coinciding with sync
        irq_n = 4'hF;
        edge_(0);
        nmi_n = 0;
        edge_(1);
        chk("nmi_coinc_not", int'(take_nmi), 0);
        chk("nmi_coinc_vec", int'(vec_lo), 'hFE);
        nmi_n = 1;
        edge_(1);
        chk("nmi_coinc_later", int'(take_nmi), 1);

        // Held-low NMI triggers once
        nmi_n = 0;
        edge_(0);
        edge_(1);
        chk("nmi_hold_first", int'(take_nmi), 1);
        edge_(1);
        chk("nmi_hold_no_retrig", int'(take_nmi), 0);
        nmi_n = 1;
        edge_(0);

        // Pending NMI discarded by reset
        nmi_n = 0;
        edge_(0);
        nmi_n = 1;
        rst = 1;
        edge_(0);
        rst = 0;
        edge_(1);
        chk("nmi_rst_take_rst", int'(take_rst), 1);
        edge_(1);
        chk("nmi_rst_no_nmi", int'(take_nmi), 0);
        chk("nmi_rst_vec", int'(vec_lo), 'hFE);

        edge_(0);
        edge_(0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/int_ctrl.md
# int_ctrl

Parametrised interrupt sequencer for the 6502 core, the successor of the fixed reset/NMI/IRQ sequencer. It samples one edge-triggered NMI line and `NUM_IRQ` level-triggered IRQ lines, and arbitrates them at each instruction boundary (`sync`). It presents the winning event to the microcode together with the low byte of its vector address. Per-channel IRQ masking and optional round-robin arbitration are new relative to the single-IRQ sequencer.

## Interface
Parameters:
- `NUM_IRQ`, default 4: number of IRQ channels, 1..8.
- `ID_W`, default 2: width of `irq_id`; must satisfy 2^`ID_W` >= `NUM_IRQ`.
- `IRQ_VEC_BASE`, default 8'hE0: vector low byte for IRQ channels 1 and above.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sync` in 1: opcode-fetch cycle flag from the instruction sequencer; arbitration point.
- `i_flag` in 1: I bit of the status register; 1 blocks all IRQs.
- `nmi_n` in 1: NMI request, active-low, falling-edge triggered.
- `irq_n` in `NUM_IRQ`: IRQ requests, active-low, level triggered.
- `mask_wr` in 1: load the mask register.
- `mask_din` in `NUM_IRQ`: new mask value; 1 enables the channel.
- `take_rst` out 1: reset sequence selected for the current instruction.
- `take_nmi` out 1: NMI sequence selected.
- `take_irq` out 1: IRQ sequence selected.
- `irq_id` out `ID_W`: winning IRQ channel index.
- `vec_lo` out 8: vector address low byte for the microcode data mux.
- `mask` out `NUM_IRQ`: current mask register.

## Operation
- Input stage, every edge:
  - `nmi_q <= nmi_n`.
  - `irq_q <= ~irq_n`.
- NMI pending: `nmi_pend` is set at an edge where `nmi_q`=1 and `nmi_n`=0. It is cleared only when NMI is taken. Set wins over clear on the same edge.
- Reset pending: `rst_pend` is 1 during and after reset, until the first `sync` edge.
- Eligible IRQs: `elig[k] = irq_q[k] & mask[k] & ~i_flag`. Level triggered: nothing latches, and a request dropped before `sync` is lost.
- Arbitration happens at an edge with `sync`=1, using pre-edge state. Priority is reset > NMI > IRQ. The winner is registered into `take_*`, `irq_id` and `vec_lo`, which are held until the next `sync` edge.
- Vectors:
  - reset: 8'hFC
  - NMI: 8'hFA
  - IRQ channel 0: 8'hFE
  - IRQ channel k>=1: `IRQ_VEC_BASE` + 2*(k-1)
  - nothing selected: all take outputs 0, `irq_id`=0, `vec_lo`=8'hFE (BRK vector)
- Taking reset clears `rst_pend` only. A pending NMI survives and is taken at the next `sync`.
- Taking NMI clears `nmi_pend`.
- Mask: `mask_wr` loads `mask_din` at the edge. Arbitration on that same edge uses the old mask.
- Exactly one of `take_rst`/`take_nmi`/`take_irq` is 1, or none.

## Timing
- Reset values (while `rst`=1 and after the reset edge):
  - `take_rst`=1, `take_nmi`=0, `take_irq`=0
  - `irq_id`=0, `vec_lo`=8'hFC
  - `mask`=all ones
  - `nmi_q`=1, `irq_q`=0, `nmi_pend`=0, `rst_pend`=1
  - round-robin pointer=0
- A reset mid-operation discards all pending NMI and IRQ state.
- NMI latency: `nmi_n` is low at edge E0, where `nmi_q` was 1, so `nmi_pend`=1 after E0. The earliest take is the first `sync` edge after E0. An edge at E0 coinciding with a `sync` edge is not taken at that edge.
- IRQ latency: `irq_n` low before edge E0 gives `irq_q` after E0. The earliest take is the first `sync` edge after E0.
- Outputs are registered only; there is no combinational path from inputs to outputs.
- The NMI edge detector needs `nmi_n` high for at least one edge before a new falling edge counts. NMI held low never re-triggers.

## Configuration
- `INT_CTRL_RR_EN` defined: round-robin IRQ arbitration.
  - A pointer holds (last granted channel + 1) mod `NUM_IRQ` and updates only when an IRQ is taken.
  - The search starts at the pointer and wraps.
- `INT_CTRL_RR_EN` undefined: fixed priority, lowest-index eligible channel wins. The pointer logic is absent.

## Test plan
- Reset release: hold `rst` 3 cycles, then one `sync` -> `take_rst`=1, `vec_lo`=8'hFC until that edge. Afterwards all take outputs are 0 and `vec_lo`=8'hFE at the next `sync`.
- NMI vs IRQ: pulse `nmi_n` low for 1 cycle with `irq_n`=4'b1110 and `i_flag`=0, then `sync` -> `take_nmi`=1, `vec_lo`=8'hFA. Next `sync` -> `take_irq`=1, `irq_id`=0, `vec_lo`=8'hFE.
- Masking: `mask_din`=4'b1101 written, `irq_n`=4'b1001, then `sync` -> channel 2 taken, `irq_id`=2, `vec_lo`=8'hE2. Repeat with `i_flag`=1 -> no take.
- Arbitration with `irq_n`=4'b0000 held over 4 `sync` edges:
  - With `INT_CTRL_RR_EN`: `irq_id`=0,1,2,3.
  - Without it: `irq_id`=0,0,0,0.
- Boundaries:
  - NMI falling edge on the same edge as `sync` -> not taken then, taken at the following `sync`.
  - NMI pending across a `rst` pulse -> cleared; reset taken, no NMI.
